// File: rtl/robot_pkg.sv
// robot_pkg
//   Shared definitions for the random parameter generator that feeds the
//   motion-decision FSM: sequencer state encoding, LFSR feedback taps, and
//   the angle/time range constants with their mapping helpers.
//   No ports (package).
package robot_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    RED1    = 3'd2,
    RED2    = 3'd3,
    PRESENT = 3'd4
  } state_e;

  // x^16 + x^14 + x^13 + x^11 + 1, expressed as register bits 15/13/12/10
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [9:0]  ANGLE_FULL = 10'd360;
  localparam logic [9:0]  TIME_SAT   = 10'd1023;

  // One conditional-subtract stage of the modulo-360 reduction.
  function automatic logic [9:0] reduce_angle(input logic [9:0] a);
    return (a >= ANGLE_FULL) ? (a - ANGLE_FULL) : a;
  endfunction

  // Floor plus masked raw time, summed at 11 bits so overflow can saturate.
  function automatic logic [9:0] map_time(input logic [9:0] raw,
                                          input logic [9:0] tmin,
                                          input logic [9:0] tmask);
    logic [10:0] sum;
    sum = {1'b0, tmin} + {1'b0, raw & tmask};
    return sum[10] ? TIME_SAT : sum[9:0];
  endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16
//   Free-running 16-bit Fibonacci LFSR (shift left, parity of tap bits
//   enters at bit 0). Shifts every cycle; a load overrides the shift.
//   The all-zero lock-up state is escaped by reloading SEED.
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset (loads SEED)
//   load      in   load load_val instead of shifting this cycle
//   load_val  in   16-bit value to load
//   q         out  current LFSR state
module lfsr16
  import robot_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] q
);

  logic [15:0] q_q;
  logic [15:0] q_d;

  always_comb begin
    q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
    if (load) begin
      q_d = load_val;
    end else if (q_q == 16'h0000) begin
      q_d = SEED;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/random_param_gen.sv
// random_param_gen
//   Supplies RandomTime/RandomAngle to the motion-decision FSM. A RandomLoad
//   request captures the free-running LFSR, reduces the angle into 0..359
//   over two subtract stages, floors and saturates the time, and presents
//   both with a one-cycle rand_valid pulse. One request can be queued while
//   busy; further requests during that time are dropped.
//   Optional macro RAND_SEED_LOAD_EN adds seed_load/seed_in to reseed the
//   LFSR at run time (seed_in of zero loads SEED).
// Ports
//   clk          in   system clock, rising edge
//   rst          in   asynchronous active-low reset
//   RandomLoad   in   request, level-sampled every clock
//   seed_load    in   (RAND_SEED_LOAD_EN) reseed LFSR this cycle
//   seed_in      in   (RAND_SEED_LOAD_EN) reseed value
//   RandomTime   out  mapped drive time, held between updates
//   RandomAngle  out  mapped turn angle 0..359, held between updates
//   rand_valid   out  one-cycle pulse with new output values
//   busy         out  high whenever the sequencer is not IDLE
//
// state   | meaning
// IDLE    | waiting for a request or a pending request
// CAPTURE | latch raw angle/time bits from the LFSR
// RED1    | first angle reduction stage
// RED2    | second angle reduction stage (angle now 0..359)
// PRESENT | drive outputs and pulse rand_valid
module random_param_gen
  import robot_pkg::*;
#(
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter logic [9:0]  TIME_MIN  = 10'd8,
  parameter logic [9:0]  TIME_MASK = 10'h0FF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RandomLoad,
`ifdef RAND_SEED_LOAD_EN
  input  logic        seed_load,
  input  logic [15:0] seed_in,
`endif
  output logic [9:0]  RandomTime,
  output logic [9:0]  RandomAngle,
  output logic        rand_valid,
  output logic        busy
);

  logic [15:0] lfsr;
  logic        lfsr_load;
  logic [15:0] lfsr_load_val;

`ifdef RAND_SEED_LOAD_EN
  assign lfsr_load     = seed_load;
  assign lfsr_load_val = (seed_in == 16'h0000) ? SEED : seed_in;
`else
  assign lfsr_load     = 1'b0;
  assign lfsr_load_val = SEED;
`endif

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .load     (lfsr_load),
    .load_val (lfsr_load_val),
    .q        (lfsr)
  );

  state_e      state_q;
  logic        pending_q;
  logic [9:0]  raw_a_q;
  logic [9:0]  raw_t_q;
  logic [9:0]  time_q;
  logic [9:0]  angle_q;
  logic        valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      raw_a_q   <= '0;
      raw_t_q   <= '0;
      time_q    <= '0;
      angle_q   <= '0;
      valid_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      // Any request outside IDLE (PRESENT included) queues one deep; a
      // request while already pending leaves the flag set, i.e. is dropped.
      if ((state_q != IDLE) && RandomLoad) begin
        pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (RandomLoad || pending_q) begin
            state_q   <= CAPTURE;
            pending_q <= 1'b0;
          end
        end
        CAPTURE: begin
          raw_a_q <= lfsr[9:0];
          raw_t_q <= lfsr[15:6];
          state_q <= RED1;
        end
        RED1: begin
          raw_a_q <= reduce_angle(raw_a_q);
          state_q <= RED2;
        end
        RED2: begin
          raw_a_q <= reduce_angle(raw_a_q);
          state_q <= PRESENT;
        end
        PRESENT: begin
          angle_q <= raw_a_q;
          time_q  <= map_time(raw_t_q, TIME_MIN, TIME_MASK);
          valid_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RandomTime  = time_q;
  assign RandomAngle = angle_q;
  assign rand_valid  = valid_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_random_param_gen.sv
// tb_random_param_gen
//   Self-checking bench for random_param_gen. Two instances share stimulus:
//   one with default parameters, one with TIME_MIN=1000/TIME_MASK=3FF so time
//   saturation is exercised. Expected values come from a behavioural model:
//   the LFSR as a polynomial recurrence, angle as raw modulo 360, time as
//   integer floor-plus-mask clipped at 1023.
module tb_random_param_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RandomLoad = 1'b0;
  logic [9:0] rt, ra, rt_s, ra_s;
  logic       rv, rv_s, busy, busy_s;
`ifdef RAND_SEED_LOAD_EN
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = 16'h0000;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [15:0] m_lfsr = SEED;

  always #5 clk = ~clk;

  random_param_gen dut (
    .clk         (clk),
    .rst         (rst),
    .RandomLoad  (RandomLoad),
`ifdef RAND_SEED_LOAD_EN
    .seed_load   (seed_load),
    .seed_in     (seed_in),
`endif
    .RandomTime  (rt),
    .RandomAngle (ra),
    .rand_valid  (rv),
    .busy        (busy)
  );

  random_param_gen #(.TIME_MIN(10'd1000), .TIME_MASK(10'h3FF)) dut_sat (
    .clk         (clk),
    .rst         (rst),
    .RandomLoad  (RandomLoad),
`ifdef RAND_SEED_LOAD_EN
    .seed_load   (seed_load),
    .seed_in     (seed_in),
`endif
    .RandomTime  (rt_s),
    .RandomAngle (ra_s),
    .rand_valid  (rv_s),
    .busy        (busy_s)
  );

  // Polynomial x^16+x^14+x^13+x^11+1: new bit is parity of bits 15,13,12,10.
  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    int ones;
    if (x == 16'h0000) return SEED;
    ones = int'(x[15]) + int'(x[13]) + int'(x[12]) + int'(x[10]);
    return (x << 1) | 16'(ones % 2);
  endfunction

  function automatic int exp_angle(input logic [15:0] c);
    return int'(c[9:0]) % 360;
  endfunction

  function automatic int exp_time(input logic [15:0] c, input int tmin, input int tmask);
    int s;
    s = tmin + (int'(c[15:6]) & tmask);
    return (s > 1023) ? 1023 : s;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_lfsr = SEED;
    end else begin
      m_lfsr = lfsr_step(m_lfsr);
`ifdef RAND_SEED_LOAD_EN
      if (seed_load) m_lfsr = (seed_in == 16'h0000) ? SEED : seed_in;
`endif
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one request from IDLE (caller at a negedge) and check the whole
  // response window; returns the captured LFSR value.
  task automatic do_request(input string tag, output logic [15:0] cap);
    RandomLoad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    RandomLoad = 1'b0;
`ifdef RAND_SEED_LOAD_EN
    seed_load = 1'b0;
`endif
    cap = m_lfsr;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      n_chk++;
      if (rv !== (k == 4)) begin
        n_fail++;
        $display("FAIL %s valid k=%0d: got %b expected %b", tag, k, rv, (k == 4));
      end
      n_chk++;
      if (busy !== (k < 4)) begin
        n_fail++;
        $display("FAIL %s busy k=%0d: got %b expected %b", tag, k, busy, (k < 4));
      end
      if (k >= 4) begin
        n_chk++;
        if (ra !== 10'(exp_angle(cap)) || ra_s !== 10'(exp_angle(cap))) begin
          n_fail++;
          $display("FAIL %s angle k=%0d: got %0d/%0d expected %0d", tag, k, ra, ra_s, exp_angle(cap));
        end
        n_chk++;
        if (rt !== 10'(exp_time(cap, 8, 'h0FF))) begin
          n_fail++;
          $display("FAIL %s time k=%0d: got %0d expected %0d", tag, k, rt, exp_time(cap, 8, 'h0FF));
        end
        n_chk++;
        if (rt_s !== 10'(exp_time(cap, 1000, 'h3FF))) begin
          n_fail++;
          $display("FAIL %s time_sat k=%0d: got %0d expected %0d", tag, k, rt_s, exp_time(cap, 1000, 'h3FF));
        end
      end
    end
  endtask

  // Wait until the next capture would see (lfsr & mask) == val, then request.
  task automatic request_when(input string tag, input logic [15:0] mask,
                              input logic [15:0] val, output logic [15:0] cap);
    int steps;
    steps = 0;
    cap = 16'h0000;
    while (((lfsr_step(m_lfsr) & mask) != val) && steps < 16000) begin
      @(negedge clk);
      steps++;
    end
    n_chk++;
    if (steps >= 16000) begin
      n_fail++;
      $display("FAIL %s search: got timeout after %0d cycles expected pattern %h", tag, steps, val);
    end else begin
      do_request(tag, cap);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (rt !== 10'd0 || ra !== 10'd0 || rt_s !== 10'd0 || ra_s !== 10'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got %0d %0d %0d %0d expected 0", rt, ra, rt_s, ra_s);
    end
    n_chk++;
    if (rv !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset flags: got valid=%b busy=%b expected 0 0", rv, busy);
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_chk++;
      if (dut.lfsr !== m_lfsr) begin
        n_fail++;
        $display("FAIL reset lfsr cycle %0d: got %h expected %h", i, dut.lfsr, m_lfsr);
      end
    end
  endtask

  task automatic test_random_requests();
    logic [15:0] cap;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 7)) @(negedge clk);
      do_request("random", cap);
    end
  endtask

  task automatic test_angle_bounds();
    logic [15:0] cap;
    request_when("angle1000", 16'h03FF, 16'd1000, cap);
    n_chk++;
    if (ra !== 10'd280) begin
      n_fail++;
      $display("FAIL angle1000: got %0d expected 280", ra);
    end
    request_when("angle359", 16'h03FF, 16'd359, cap);
    n_chk++;
    if (ra !== 10'd359) begin
      n_fail++;
      $display("FAIL angle359: got %0d expected 359", ra);
    end
    request_when("angle360", 16'h03FF, 16'd360, cap);
    n_chk++;
    if (ra !== 10'd0) begin
      n_fail++;
      $display("FAIL angle360: got %0d expected 0", ra);
    end
  endtask

  task automatic test_time_sat();
    logic [15:0] cap;
    request_when("time3ff", 16'hFFC0, 16'hFFC0, cap);
    n_chk++;
    if (rt_s !== 10'd1023 || rt !== 10'd263) begin
      n_fail++;
      $display("FAIL time3ff: got %0d/%0d expected 1023/263", rt_s, rt);
    end
    request_when("time0", 16'hFFC0, 16'h0000, cap);
    n_chk++;
    if (rt_s !== 10'd1000 || rt !== 10'd8) begin
      n_fail++;
      $display("FAIL time0: got %0d/%0d expected 1000/8", rt_s, rt);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cap1, cap2;
    int pulses;
    pulses = 0;
    cap2 = 16'h0000;
    RandomLoad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cap1 = m_lfsr;
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk);
      RandomLoad = (k == 1) || (k == 2);
      if (k == 5) cap2 = m_lfsr;
      if (rv === 1'b1) pulses++;
      n_chk++;
      if (rv !== ((k == 4) || (k == 9))) begin
        n_fail++;
        $display("FAIL b2b valid k=%0d: got %b expected %b", k, rv, ((k == 4) || (k == 9)));
      end
      if (k == 4 || k == 9) begin
        n_chk++;
        if (ra !== 10'(exp_angle(k == 4 ? cap1 : cap2)) ||
            rt_s !== 10'(exp_time(k == 4 ? cap1 : cap2, 1000, 'h3FF))) begin
          n_fail++;
          $display("FAIL b2b values k=%0d: got %0d/%0d expected %0d/%0d", k, ra, rt_s,
                   exp_angle(k == 4 ? cap1 : cap2), exp_time(k == 4 ? cap1 : cap2, 1000, 'h3FF));
        end
      end
    end
    n_chk++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL b2b pulse count: got %0d expected 2", pulses);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] cap;
    RandomLoad = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // Still high: sampled in CAPTURE, so it becomes pending.
    @(negedge clk);
    RandomLoad = 1'b0;
    rst = 1'b0;
    #1;
    n_chk++;
    if (rt !== 10'd0 || ra !== 10'd0 || rv !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset outputs: got t=%0d a=%0d v=%b b=%b expected 0", rt, ra, rv, busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_chk++;
      if (rv !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL midreset pending cycle %0d: got v=%b b=%b expected 0 0", i, rv, busy);
      end
    end
    do_request("after_reset", cap);
  endtask

`ifdef RAND_SEED_LOAD_EN
  task automatic test_seed_load();
    logic [15:0] cap;
    seed_load = 1'b1;
    seed_in   = 16'hFFE8;
    @(negedge clk);
    seed_load = 1'b0;
    n_chk++;
    if (busy !== 1'b0 || dut.lfsr !== 16'hFFE8) begin
      n_fail++;
      $display("FAIL seed idle: got busy=%b lfsr=%h expected 0 ffe8", busy, dut.lfsr);
    end
    seed_load = 1'b1;
    seed_in   = 16'hFFE8;
    do_request("seed_ffe8", cap);
    n_chk++;
    if (ra !== 10'd280 || rt_s !== 10'd1023) begin
      n_fail++;
      $display("FAIL seed_ffe8: got %0d/%0d expected 280/1023", ra, rt_s);
    end
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    do_request("seed_zero", cap);
    n_chk++;
    if (cap !== SEED) begin
      n_fail++;
      $display("FAIL seed_zero capture: got %h expected %h", cap, SEED);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_random_requests();
    test_angle_bounds();
    test_time_sat();
    test_back_to_back();
    test_reset_mid();
`ifdef RAND_SEED_LOAD_EN
    test_seed_load();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
